// File: rtl/rx_sample_decimator.sv
// Integrate-and-dump I/Q decimator: sums decimation_g valid ADC samples,
// scales by a Q1.15 gain, rounds half up and saturates to the output width.
module rx_sample_decimator #(
  parameter int in_bit_width_g     = 12,
  parameter int sample_bit_width_g = 12,
  parameter int decimation_g       = 25,
  parameter int acc_bit_width_g    = 17,
  parameter int gain_g             = 1311
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rstn,
  input  logic                                 sys_init,
  input  logic signed [in_bit_width_g-1:0]     adc_i,
  input  logic signed [in_bit_width_g-1:0]     adc_q,
  input  logic                                 adc_valid,
  output logic signed [sample_bit_width_g-1:0] rx_data_i,
  output logic signed [sample_bit_width_g-1:0] rx_data_q,
  output logic                                 rx_data_valid,
  output logic                                 sat_flag
);

  localparam int CW = (decimation_g > 1) ? $clog2(decimation_g) : 1;
  localparam int AW = acc_bit_width_g;
  localparam int PW = acc_bit_width_g + 17;
  localparam int RW = PW - 15;
  localparam int SW = sample_bit_width_g;

  localparam logic [CW-1:0]        LAST = CW'(decimation_g - 1);
  localparam logic signed [PW-1:0] GAIN = PW'(gain_g);
  localparam logic signed [PW-1:0] HALF = PW'(1 << 14);
  localparam logic signed [RW-1:0] SMAX = RW'((1 << (SW - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = RW'(-(1 << (SW - 1)));

  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] ext_i, ext_q;
  logic signed [AW-1:0] acc_i, acc_q;
  logic signed [AW-1:0] dump_i, dump_q;
  logic                 dump_valid;
  logic signed [PW-1:0] prod_i, prod_q;
  logic                 p_valid;
  logic signed [RW-1:0] r_i, r_q;
  logic [SW-1:0]        clip_i, clip_q;
  logic                 hit_i, hit_q;

  // Returns {clipped, value}; clipped is set when r falls outside the output range.
  function automatic logic [SW:0] clip_fn(input logic signed [RW-1:0] r);
    if (r > SMAX)      clip_fn = {1'b1, SMAX[SW-1:0]};
    else if (r < SMIN) clip_fn = {1'b1, SMIN[SW-1:0]};
    else               clip_fn = {1'b0, r[SW-1:0]};
  endfunction

  assign ext_i = AW'(adc_i);
  assign ext_q = AW'(adc_q);

  // The closing sample goes straight into the dump so blocks stay contiguous.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt        <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      dump_i     <= '0;
      dump_q     <= '0;
      dump_valid <= 1'b0;
    end else if (sys_init) begin
      cnt        <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      dump_valid <= 1'b0;
    end else if (adc_valid) begin
      if (cnt == LAST) begin
        dump_i     <= acc_i + ext_i;
        dump_q     <= acc_q + ext_q;
        dump_valid <= 1'b1;
        acc_i      <= '0;
        acc_q      <= '0;
        cnt        <= '0;
      end else begin
        acc_i      <= acc_i + ext_i;
        acc_q      <= acc_q + ext_q;
        cnt        <= cnt + 1'b1;
        dump_valid <= 1'b0;
      end
    end else begin
      dump_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      prod_i  <= '0;
      prod_q  <= '0;
      p_valid <= 1'b0;
    end else begin
      prod_i  <= PW'(dump_i) * GAIN;
      prod_q  <= PW'(dump_q) * GAIN;
      p_valid <= sys_init ? 1'b0 : dump_valid;
    end
  end

  always_comb begin
    r_i = RW'((prod_i + HALF) >>> 15);
    r_q = RW'((prod_q + HALF) >>> 15);
    {hit_i, clip_i} = clip_fn(r_i);
    {hit_q, clip_q} = clip_fn(r_q);
  end

  // Output data only updates on a real result, so it holds across init.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_data_i     <= '0;
      rx_data_q     <= '0;
      rx_data_valid <= 1'b0;
      sat_flag      <= 1'b0;
    end else if (sys_init) begin
      rx_data_valid <= 1'b0;
      sat_flag      <= 1'b0;
    end else begin
      rx_data_valid <= p_valid;
      if (p_valid) begin
        rx_data_i <= clip_i;
        rx_data_q <= clip_q;
        if (hit_i || hit_q) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_sample_decimator.sv
// Scoreboard bench for rx_sample_decimator: two instances (gain 1311 and 2622)
// share one stimulus stream; a block-level model predicts value, timing and sat_flag.
module tb_rx_sample_decimator;

  localparam int DEC = 25;
  localparam int SW  = 12;

  typedef struct {
    longint i;
    longint q;
    bit     sat;
    int     cyc;
  } exp_t;

  logic                 sys_clk = 1'b0;
  logic                 sys_rstn = 1'b0;
  logic                 sys_init = 1'b0;
  logic signed [11:0]   adc_i = '0;
  logic signed [11:0]   adc_q = '0;
  logic                 adc_valid = 1'b0;
  logic signed [SW-1:0] rx_i0, rx_q0, rx_i1, rx_q1;
  logic                 rx_v0, rx_v1, sat0, sat1;

  int     checks = 0;
  int     errors = 0;
  int     edge_cnt = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  longint m_acc_i = 0, m_acc_q = 0;
  int     m_cnt = 0;
  bit     sticky0 = 0, sticky1 = 0;
  longint last_i0 = 0, last_q0 = 0;

  rx_sample_decimator u_dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .sys_init(sys_init),
    .adc_i(adc_i), .adc_q(adc_q), .adc_valid(adc_valid),
    .rx_data_i(rx_i0), .rx_data_q(rx_q0), .rx_data_valid(rx_v0), .sat_flag(sat0)
  );

  rx_sample_decimator #(.gain_g(2622)) u_dut_sat (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .sys_init(sys_init),
    .adc_i(adc_i), .adc_q(adc_q), .adc_valid(adc_valid),
    .rx_data_i(rx_i1), .rx_data_q(rx_q1), .rx_data_valid(rx_v1), .sat_flag(sat1)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint model_out(input longint acc, input longint gain, output bit hit);
    longint r;
    r = (acc * gain + 16384) >>> 15;
    hit = 1'b0;
    if (r > 2047) begin r = 2047; hit = 1'b1; end
    else if (r < -2048) begin r = -2048; hit = 1'b1; end
    return r;
  endfunction

  task automatic flush_model();
    q0.delete();
    q1.delete();
    m_acc_i = 0;
    m_acc_q = 0;
    m_cnt   = 0;
    sticky0 = 0;
    sticky1 = 0;
  endtask

  // One clock of stimulus; the model advances on the same edge the DUT samples.
  task automatic apply_stimulus(input bit v, input longint i, input longint q, input bit init);
    exp_t e0, e1;
    bit   hi, hq;
    adc_valid = v;
    adc_i     = 12'(i);
    adc_q     = 12'(q);
    sys_init  = init;
    @(posedge sys_clk);
    #1;
    if (init) begin
      flush_model();
    end else if (v) begin
      m_acc_i += i;
      m_acc_q += q;
      m_cnt++;
      if (m_cnt == DEC) begin
        e0.i = model_out(m_acc_i, 1311, hi);
        e0.q = model_out(m_acc_q, 1311, hq);
        sticky0 = sticky0 | hi | hq;
        e0.sat = sticky0;
        e0.cyc = edge_cnt + 2;
        q0.push_back(e0);
        e1.i = model_out(m_acc_i, 2622, hi);
        e1.q = model_out(m_acc_q, 2622, hq);
        sticky1 = sticky1 | hi | hq;
        e1.sat = sticky1;
        e1.cyc = edge_cnt + 2;
        q1.push_back(e1);
        m_acc_i = 0;
        m_acc_q = 0;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(0, 0, 0, 0);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rstn && rx_v0) begin
      if (q0.size() == 0) check_output("unexpected_pulse0", 1, 0);
      else begin
        e = q0.pop_front();
        check_output("data_i0", rx_i0, e.i);
        check_output("data_q0", rx_q0, e.q);
        check_output("sat0", sat0, e.sat);
        check_output("latency0", edge_cnt, e.cyc);
        last_i0 = e.i;
        last_q0 = e.q;
      end
    end
    if (sys_rstn && rx_v1) begin
      if (q1.size() == 0) check_output("unexpected_pulse1", 1, 0);
      else begin
        e = q1.pop_front();
        check_output("data_i1", rx_i1, e.i);
        check_output("data_q1", rx_q1, e.q);
        check_output("sat1", sat1, e.sat);
        check_output("latency1", edge_cnt, e.cyc);
      end
    end
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check_output("rst_valid", rx_v0, 0);
    check_output("rst_i", rx_i0, 0);
    check_output("rst_q", rx_q0, 0);
    check_output("rst_sat", sat0, 0);
    sys_rstn = 1'b1;

    $display("[TB] DC blocks");
    for (int k = 0; k < 3 * DEC; k++) apply_stimulus(1, 1000, -1000, 0);
    idle(4);
    check_output("dc_sat0", sat0, 0);

    $display("[TB] full scale");
    for (int k = 0; k < DEC; k++) apply_stimulus(1, -2048, 2047, 0);
    idle(4);
    check_output("fs_sat0", sat0, 0);
    check_output("fs_sat1", sat1, 1);

    apply_stimulus(0, 0, 0, 1);
    #2;
    check_output("init_clears_sat1", sat1, 0);
    check_output("init_holds_i0", rx_i0, last_i0);
    check_output("init_holds_q0", rx_q0, last_q0);

    $display("[TB] saturation");
    for (int k = 0; k < DEC; k++) apply_stimulus(1, 2047, 0, 0);
    idle(4);
    check_output("satblk_sat1", sat1, 1);
    apply_stimulus(0, 0, 0, 1);
    idle(1);

    $display("[TB] gapped ramp");
    for (int k = 0; k < DEC; k++) begin
      apply_stimulus(1, k, -k, 0);
      idle(2);
    end
    idle(3);
    check_output("ramp_value", last_i0, 12);

    $display("[TB] init mid-block");
    for (int k = 0; k < 10; k++) apply_stimulus(1, 500, 500, 0);
    apply_stimulus(1, 500, 500, 1);
    for (int k = 0; k < DEC; k++) apply_stimulus(1, 200, -200, 0);
    idle(4);
    check_output("init_block_i", last_i0, 200);

    $display("[TB] reset mid-pipeline");
    for (int k = 0; k < DEC; k++) apply_stimulus(1, 300, 300, 0);
    idle(1);
    sys_rstn = 1'b0;
    flush_model();
    last_i0 = 0;
    last_q0 = 0;
    @(negedge sys_clk);
    check_output("midrst_valid", rx_v0, 0);
    check_output("midrst_i", rx_i0, 0);
    check_output("midrst_q", rx_q0, 0);
    sys_rstn = 1'b1;
    idle(4);
    check_output("post_rst_valid", rx_v0, 0);
    for (int k = 0; k < DEC; k++) apply_stimulus(1, 123, -77, 0);
    idle(4);
    check_output("post_rst_i", last_i0, 123);

    check_output("pending0", q0.size(), 0);
    check_output("pending1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
